shift_pipe: RTL and testbench

SHIFT_PIPE -- requirements
Module: shift_pipe

---
 rtl/shift_pkg.sv | 13 +
 rtl/shift_stage.sv | 46 ++++
 rtl/shift_pipe.sv | 163 ++++++++++++++++
 tb/tb_shift_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the shift pipeline: op encoding and its width.
package shift_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROR = 2'b11
  } shift_op_t;

endpackage

// File: rtl/shift_stage.sv
// Combinational group of right-shift levels LO..HI-1 (HI exclusive).
// Wrap muxing exists only when SHIFT_PIPE_ROTATE_EN is defined.
module shift_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = $clog2(WIDTH),
  parameter int LO    = 0,
  parameter int HI    = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [DEPTH-1:0] b_i,
  input  logic             fill_i,
`ifdef SHIFT_PIPE_ROTATE_EN
  input  logic             rot_i,
`endif
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] lvl [LO:HI];
  logic             unused_b;

  assign lvl[LO]  = data_i;
  assign unused_b = ^b_i;

  for (genvar j = LO; j < HI; j++) begin : g_lvl
    localparam int SH = 1 << j;
    logic [WIDTH-1:0] shifted;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam int SRC = (i + SH) % WIDTH;
      if (i + SH < WIDTH) begin : g_in
        assign shifted[i] = lvl[j][SRC];
      end else begin : g_edge
`ifdef SHIFT_PIPE_ROTATE_EN
        assign shifted[i] = rot_i ? lvl[j][SRC] : fill_i;
`else
        assign shifted[i] = fill_i;
`endif
      end
    end

    assign lvl[j+1] = b_i[j] ? shifted : lvl[j];
  end

  assign data_o = lvl[HI];

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshake and tag.
// Define SHIFT_PIPE_ROTATE_EN to make op 11 rotate right; otherwise it acts as SRL.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = $clog2(WIDTH),
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [DEPTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] valid_q, valid_d, fill_q, fill_d, rev_q, rev_d, load;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [DEPTH-1:0]  b_q    [STAGES];
  logic [DEPTH-1:0]  b_d    [STAGES];
  shift_op_t         op_q   [STAGES];
  shift_op_t         op_d   [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [TAG_W-1:0]  tag_d  [STAGES];

  logic [STAGES-1:0] stg_valid, stg_fill, stg_rev;
  logic [WIDTH-1:0]  stg_data [STAGES];
  logic [WIDTH-1:0]  stg_res  [STAGES];
  logic [DEPTH-1:0]  stg_b    [STAGES];
  shift_op_t         stg_op   [STAGES];
  logic [TAG_W-1:0]  stg_tag  [STAGES];

  shift_op_t        op_in;
  logic [WIDTH-1:0] a_pre;
  logic             unused_tail;

  // Left shifts run through the right-shift datapath on a bit-reversed operand.
  assign op_in = shift_op_t'(in_op);

  always_comb begin
    a_pre = in_a;
    if (op_in == SLL) begin
      for (int i = 0; i < WIDTH; i++) a_pre[i] = in_a[WIDTH-1-i];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign stg_valid[s] = in_valid && in_ready;
      assign stg_data[s]  = a_pre;
      assign stg_b[s]     = in_b;
      assign stg_op[s]    = op_in;
      assign stg_fill[s]  = (op_in == SRA) && in_a[WIDTH-1];
      assign stg_rev[s]   = (op_in == SLL);
      assign stg_tag[s]   = in_tag;
    end else begin : g_body
      assign stg_valid[s] = valid_q[s-1];
      assign stg_data[s]  = data_q[s-1];
      assign stg_b[s]     = b_q[s-1];
      assign stg_op[s]    = op_q[s-1];
      assign stg_fill[s]  = fill_q[s-1];
      assign stg_rev[s]   = rev_q[s-1];
      assign stg_tag[s]   = tag_q[s-1];
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .LO    (s * DEPTH / STAGES),
      .HI    ((s + 1) * DEPTH / STAGES)
    ) u_stage (
      .data_i (stg_data[s]),
      .b_i    (stg_b[s]),
      .fill_i (stg_fill[s]),
`ifdef SHIFT_PIPE_ROTATE_EN
      .rot_i  (stg_op[s] == ROR),
`endif
      .data_o (stg_res[s])
    );
  end

  // Stage k may load unless it and every stage after it are full while out_ready is low.
  always_comb begin
    logic full_tail;
    full_tail = 1'b1;
    load      = '0;
    for (int k = 0; k < STAGES; k++) begin
      full_tail = 1'b1;
      for (int m = k; m < STAGES; m++) full_tail = full_tail & valid_q[m];
      load[k] = out_ready || !full_tail;
    end
  end

  assign in_ready = load[0] && !flush && !rst;

  always_comb begin
    valid_d = valid_q;
    fill_d  = fill_q;
    rev_d   = rev_q;
    data_d  = data_q;
    b_d     = b_q;
    op_d    = op_q;
    tag_d   = tag_q;
    for (int k = 0; k < STAGES; k++) begin
      if (load[k]) begin
        valid_d[k] = stg_valid[k];
        data_d[k]  = stg_res[k];
        b_d[k]     = stg_b[k];
        op_d[k]    = stg_op[k];
        fill_d[k]  = stg_fill[k];
        rev_d[k]   = stg_rev[k];
        tag_d[k]   = stg_tag[k];
      end
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      fill_q  <= '0;
      rev_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        b_q[k]    <= '0;
        op_q[k]   <= SLL;
        tag_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      fill_q  <= fill_d;
      rev_q   <= rev_d;
      data_q  <= data_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    out_data = data_q[LAST];
    if (rev_q[LAST]) begin
      for (int i = 0; i < WIDTH; i++) out_data[i] = data_q[LAST][WIDTH-1-i];
    end
  end

  assign out_valid   = valid_q[LAST];
  assign out_tag     = tag_q[LAST];
  assign unused_tail = ^{b_q[LAST], op_q[LAST], fill_q[LAST]};

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (WIDTH=32, STAGES=2): directed cases plus
// a randomized stream scored against an arithmetic reference model.
module tb_shift_pipe;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 5;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_a, out_data;
  logic [DEPTH-1:0] in_b;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag, out_tag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
  } exp_t;
  exp_t exp_q[$];

  shift_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, input int b,
                                             input logic [1:0] op);
    case (op)
      2'd0:    return a << b;
      2'd1:    return a >> b;
      2'd2:    return WIDTH'($signed(a) >>> b);
`ifdef SHIFT_PIPE_ROTATE_EN
      default: return (b == 0) ? a : ((a >> b) | (a << (WIDTH - b)));
`else
      default: return a >> b;
`endif
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one op into an empty pipe with out_ready=1 and check its exact latency.
  task automatic issue_one(input string name, input logic [WIDTH-1:0] a, input int b,
                           input logic [1:0] op, input logic [TAG_W-1:0] tag,
                           input logic [WIDTH-1:0] exp);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = DEPTH'(b); in_op = op; in_tag = tag; out_ready = 1'b1;
    #1 chk({name, "_rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      #1 chk({name, "_early"}, 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    #1;
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_data"}, out_data, exp);
    chk({name, "_tag"}, 32'(out_tag), 32'(tag));
  endtask

  initial begin
    int got;
    logic acc, pop;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0; in_tag = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    rst = 1'b0;
    #1 chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Directed functional cases
    issue_one("sra_neg", 32'h8000_0000, 4, 2'd2, 4'h5, 32'hF800_0000);
    issue_one("sll_31", 32'h0000_0001, 31, 2'd0, 4'h6, 32'h8000_0000);
    issue_one("srl_31", 32'h8000_0000, 31, 2'd1, 4'h7, 32'h0000_0001);
    issue_one("sra_pos", 32'h4000_0000, 8, 2'd2, 4'h8, 32'h0040_0000);
    for (int op = 0; op < 4; op++)
      issue_one("b_zero", 32'hA5C3_1E0F, 0, 2'(op), 4'(op), 32'hA5C3_1E0F);
`ifdef SHIFT_PIPE_ROTATE_EN
    issue_one("op11", 32'h0000_000F, 4, 2'd3, 4'h9, 32'hF000_0000);
`else
    issue_one("op11", 32'h0000_000F, 4, 2'd3, 4'h9, 32'h0000_0000);
`endif

    // Backpressure: two slots fill, third refused, then drained in order
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 32'h1; in_b = '0; in_op = 2'd1; in_tag = 4'd1;
    #1 chk("bp_rdy1", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_tag = 4'd2;
    #1 chk("bp_rdy2", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_tag = 4'd3;
    #1 chk("bp_rdy3", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_tag", 32'(out_tag), 32'd1);
    chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("bp_rel_rdy", 32'(in_ready), 32'd1);
    got = 0;
    for (int cyc = 0; cyc < 8 && got < 3; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        #1;
      end
      if (out_valid) begin
        got++;
        chk("bp_order", 32'(out_tag), 32'(got));
      end
    end
    chk("bp_count", 32'(got), 32'd3);
    in_valid = 1'b0;

    // Flush with two ops in flight
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 32'h1234_5678; in_b = 5'd1; in_op = 2'd1; in_tag = 4'hA;
    @(negedge clk);
    in_tag = 4'hB;
    @(negedge clk);
    in_tag = 4'hC; flush = 1'b1;
    #1 chk("fl_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1 chk("fl_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("fl_quiet", 32'(out_valid), 32'd0);
    end
    issue_one("fl_after", 32'h0000_00F0, 4, 2'd1, 4'hD, 32'h0000_000F);

    // Reset one cycle after acceptance
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'hFFFF_0000; in_b = 5'd8; in_op = 2'd1; in_tag = 4'hE; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1 chk("mr_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_data", out_data, 32'h0);
    rst = 1'b0;
    #1 chk("mr_rel_rdy", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("mr_quiet", 32'(out_valid), 32'd0);
    end

    // Randomized stream against the reference model
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_a      = $urandom;
      in_b      = DEPTH'($urandom_range(0, WIDTH - 1));
      in_op     = 2'($urandom_range(0, 3));
      in_tag    = TAG_W'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_ready", 32'(in_ready), 32'((exp_q.size() < STAGES) || out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) chk("rnd_spurious", 32'(out_valid), 32'd0);
        else begin
          chk("rnd_data", out_data, exp_q[0].data);
          chk("rnd_tag", 32'(out_tag), 32'(exp_q[0].tag));
        end
      end
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back('{model(in_a, int'(in_b), in_op), in_tag});
    end

    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && exp_q.size() > 0; cyc++) begin
      #1;
      if (out_valid) begin
        chk("drain_data", out_data, exp_q[0].data);
        chk("drain_tag", 32'(out_tag), 32'(exp_q[0].tag));
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
